keypad_scan: RTL
================

# keypad_scan

Scans a 4x4 active-low key matrix, debounces the result over whole scan frames, and produces the `key` / `key_pulse` bus that the game graphics logic consumes. `key` holds the current debounced key for as long as it is pressed. `key_pulse` carries the same value for exactly one clock when a new key is accepted. The block sits between the board keypad pins and the game/graphics modules on the pixel clock domain.

## Interface
- `SCAN_DIV`, default 50000: clocks per column (1 ms at 50 MHz). Minimum value is 4.
- `DEBOUNCE_CNT`, default 4: number of consecutive identical frames required before `key` changes. Minimum value is 1.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high; clock `clk`.
- `row_in`  in  4: matrix rows, active-low, pulled up on the board.
- `col_out`  out  4: column drive, one-hot active-low.
- `key`  out  5: debounced key {valid, code[3:0]}, 0 when no key is held.
- `key_pulse`  out  5: {1, code} for one clock on acceptance of a new pressed key, 0 otherwise.

## Operation
- `row_in` passes through a 2-flop synchronizer. All sampling uses the synchronizer output `row_s`.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. `scan_tick` is asserted when the count equals SCAN_DIV-1.
- Column index `col_idx` (0..3) drives `col_out` = ~(1 << col_idx).
- On each `scan_tick`:
  - sample `row_s` for the current column;
  - advance `col_idx`, wrapping 3 -> 0.
- Frame accumulation:
  - Key code = 4*row + col. Row r is pressed when `row_s[r]` = 0 while column c is driven.
  - A frame is one pass over columns 0..3.
  - The frame result is the lowest pressed code with valid = 1, or 5'h00 if no key is pressed.
  - When several keys are pressed, the lowest code wins.
- On the col-3 `scan_tick`, load `frame_raw` with the frame result (including the col-3 sample) and clear the accumulator.
- Debounce, evaluated one clock after `frame_raw` loads:
  - new_cnt = (frame_raw == last_raw) ? min(cnt+1, DEBOUNCE_CNT) : 1;
  - last_raw <= frame_raw; cnt <= new_cnt.
  - If new_cnt == DEBOUNCE_CNT and frame_raw != key: key <= frame_raw.
  - In that same update, if frame_raw[4] = 1, key_pulse <= frame_raw.
- `key_pulse` returns to 0 on the next clock.
- Release (frame_raw = 0 after debounce) clears `key` and produces no pulse.
- A direct change A -> B (no release frame in between) sets key = B and pulses B.
- Holding a key produces no repeated pulses. Saturation of `cnt` is harmless.
- `cnt` width is clog2(DEBOUNCE_CNT+1). Prescaler width is clog2(SCAN_DIV).

## Timing
- Reset values: prescaler 0, col_idx 0, col_out 4'b1110, key 5'h00, key_pulse 5'h00, frame_raw 0, last_raw 0, cnt 0, accumulator cleared, synchronizer flops 4'b1111.
- Each column is driven for SCAN_DIV clocks and sampled on its last clock. Rows therefore have SCAN_DIV-2 clocks to settle through the synchronizer.
- A frame lasts 4*SCAN_DIV clocks.
- Latency: with a clean press held from before a frame start, `key` updates 1 clock after the col-3 `scan_tick` of the DEBOUNCE_CNT-th matching frame. `key_pulse` is high in the following cycle only.
- A press lasting less than DEBOUNCE_CNT full frames is never reported.
- `rst` asserted mid-frame or mid-debounce returns every register to its reset value immediately. Scanning restarts at column 0 after deassertion, and no partial-frame result survives.
- `row_in` is allowed to change at any clock. Metastability is absorbed by the synchronizer.

## Test plan
Use SCAN_DIV=4, DEBOUNCE_CNT=3, so one frame = 16 clocks.
1. Reset, no keys pressed -> col_out = 1110, 1101, 1011, 0111 in turn, each for 4 clocks, repeating; key = 0 and key_pulse = 0 throughout 10 frames.
2. Hold row1/col0 (code 4) from frame 0 -> key = 5'h14 one clock after the 3rd col-3 tick; key_pulse = 5'h14 for exactly 1 clock; held 10 more frames, no further pulses; key stays 5'h14.
3. Press code 4 only on alternate frames (bounce) for 12 frames -> key = 0 and no pulse ever. Then hold it steadily -> key = 5'h14 after 3 frames.
4. Hold codes 5 and 6 together -> key = 5'h15 with one pulse of 5'h15. Release code 5 while keeping code 6 -> key = 5'h16 after 3 frames with one pulse of 5'h16.
5. Release all keys after key = 5'h14 -> key = 0 after 3 clean frames; key_pulse stays 0.
6. Assert rst after 2 matching frames of code 4 -> key, cnt and col_out reset at once; after deassertion, 3 fresh frames are needed before key = 5'h14.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low key matrix scanner with frame-level debounce.
// Revision 1.0 - initial release.
`default_nettype none

module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] key,
  output logic [4:0] key_pulse
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PW-1:0] C_PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_DB_MAX    = CW'(DEBOUNCE_CNT);

  logic [3:0]    r_sync1;
  logic [3:0]    r_row_s;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_col_idx;
  logic [4:0]    r_acc;
  logic [4:0]    r_frame_raw;
  logic          r_eval;
  logic [4:0]    r_last_raw;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_key;
  logic [4:0]    r_key_pulse;

  logic          w_tick;
  logic          w_hit;
  logic [1:0]    w_row;
  logic [4:0]    w_col_code;
  logic [4:0]    w_merged;
  logic [CW-1:0] w_new_cnt;

  assign w_tick     = (r_presc == C_PRESC_MAX);
  assign col_out    = ~(4'b0001 << r_col_idx);
  assign key        = r_key;
  assign key_pulse  = r_key_pulse;
  assign w_col_code = {1'b1, w_row, r_col_idx};

  // Lowest pressed row in the driven column gives the lowest code in it.
  always_comb begin
    w_hit = 1'b0;
    w_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!r_row_s[r]) begin
        w_hit = 1'b1;
        w_row = 2'(r);
      end
    end
  end

  // Columns are visited in order, but a later column can still hold a lower code.
  always_comb begin
    w_merged = r_acc;
    if (w_hit && (!r_acc[4] || (w_col_code[3:0] < r_acc[3:0]))) begin
      w_merged = w_col_code;
    end
  end

  always_comb begin
    w_new_cnt = CW'(1);
    if (r_frame_raw == r_last_raw) begin
      w_new_cnt = (r_cnt >= C_DB_MAX) ? C_DB_MAX : (r_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 4'b1111;
      r_row_s     <= 4'b1111;
      r_presc     <= '0;
      r_col_idx   <= 2'd0;
      r_acc       <= 5'h00;
      r_frame_raw <= 5'h00;
      r_eval      <= 1'b0;
      r_last_raw  <= 5'h00;
      r_cnt       <= '0;
      r_key       <= 5'h00;
      r_key_pulse <= 5'h00;
    end else begin
      r_sync1     <= row_in;
      r_row_s     <= r_sync1;
      r_eval      <= 1'b0;
      r_key_pulse <= 5'h00;

      r_presc <= w_tick ? '0 : (r_presc + 1'b1);

      if (w_tick) begin
        r_col_idx <= r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          r_frame_raw <= w_merged;
          r_acc       <= 5'h00;
          r_eval      <= 1'b1;
        end else begin
          r_acc <= w_merged;
        end
      end

      // Debounce runs the clock after a frame result lands.
      if (r_eval) begin
        r_last_raw <= r_frame_raw;
        r_cnt      <= w_new_cnt;
        if ((w_new_cnt == C_DB_MAX) && (r_frame_raw != r_key)) begin
          r_key <= r_frame_raw;
          if (r_frame_raw[4]) begin
            r_key_pulse <= r_frame_raw;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
